// File: rtl/data_memory_arbiter.sv
// rtl/data_memory_arbiter.sv - round-robin arbiter in front of one single-ported data array
// An init sequencer fills the array after reset or on init_req. No grants are issued while busy.
module data_memory_arbiter #(
  parameter int                NUM_PORTS  = 2,
  parameter int                ADDR_W     = 8,
  parameter int                DATA_W     = 8,
  parameter int                INIT_MODE  = 1,
  parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        init_req,
  input  logic [NUM_PORTS-1:0]        req,
  input  logic [NUM_PORTS-1:0]        we,
  input  logic [NUM_PORTS*ADDR_W-1:0] addr,
  input  logic [NUM_PORTS*DATA_W-1:0] wdata,
  output logic [NUM_PORTS-1:0]        ack,
  output logic [NUM_PORTS*DATA_W-1:0] rdata,
  output logic                        busy
);

  localparam int PW    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int DEPTH = 2**ADDR_W;

  typedef enum logic {INIT, SERVE} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   fill_cnt;
  logic [PW-1:0]       prio;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic                gnt_valid;
  logic [PW-1:0]       gnt_idx;
  logic                gnt_we;
  logic [ADDR_W-1:0]   gnt_addr;
  logic [DATA_W-1:0]   gnt_wdata;
  logic [DATA_W-1:0]   fill_data;
  logic [DATA_W+ADDR_W-1:0] cnt_ext;

  logic [2*NUM_PORTS-1:0] req_dbl;
  logic [NUM_PORTS-1:0]   req_rot;

  assign cnt_ext = {{DATA_W{1'b0}}, fill_cnt};

  always_comb begin
    if (INIT_MODE == 0)
      fill_data = '0;
    else if (INIT_MODE == 1)
      fill_data = cnt_ext[DATA_W-1:0];
    else
      fill_data = INIT_VALUE;
  end

  // Rotate requests so bit 0 is the prio port; the lowest set bit is the winner.
  always_comb begin
    int off;
    int sum;
    off       = 0;
    sum       = 0;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    req_dbl   = {req, req} >> prio;
    req_rot   = req_dbl[NUM_PORTS-1:0];
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      if (req_rot[k]) off = k;
    end
    if (state == SERVE && req_rot != '0) begin
      gnt_valid = 1'b1;
      sum = int'(prio) + off;
      if (sum >= NUM_PORTS) sum = sum - NUM_PORTS;
      gnt_idx = PW'(sum);
    end
    gnt_we    = we[gnt_idx];
    gnt_addr  = addr[gnt_idx*ADDR_W +: ADDR_W];
    gnt_wdata = wdata[gnt_idx*DATA_W +: DATA_W];
  end

  always_ff @(posedge clk) begin
    if (state == INIT)
      mem[fill_cnt] <= fill_data;
    else if (gnt_valid && gnt_we)
      mem[gnt_addr] <= gnt_wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= INIT;
      fill_cnt <= '0;
      busy     <= 1'b1;
      prio     <= '0;
      ack      <= '0;
      rdata    <= '0;
    end else begin
      ack <= '0;
      case (state)
        INIT: begin
          fill_cnt <= fill_cnt + 1'b1;
          if (fill_cnt == '1) begin
            state <= SERVE;
            busy  <= 1'b0;
          end
        end
        default: begin
          if (init_req) begin
            state    <= INIT;
            busy     <= 1'b1;
            fill_cnt <= '0;
          end
        end
      endcase
      // A grant in the same cycle as init_req still completes.
      if (gnt_valid) begin
        ack[gnt_idx] <= 1'b1;
        if (!gnt_we) rdata[gnt_idx*DATA_W +: DATA_W] <= mem[gnt_addr];
        if (gnt_idx == PW'(NUM_PORTS - 1))
          prio <= '0;
        else
          prio <= gnt_idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_data_memory_arbiter.sv
// tb/tb_data_memory_arbiter.sv - scoreboard bench for data_memory_arbiter
module tb_data_memory_arbiter;

  typedef struct {
    int         port;
    logic [7:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        init_req = 1'b0;
  logic [1:0]  req_a = '0, we_a = '0, ack_a;
  logic [15:0] addr_a = '0, wdata_a = '0, rdata_a;
  logic        busy_a;
  logic        init_req_b = 1'b0;
  logic [2:0]  req_b = '0, we_b = '0, ack_b;
  logic [11:0] addr_b = '0;
  logic [23:0] wdata_b = '0, rdata_b;
  logic        busy_b;

  exp_t qa[$];
  exp_t qb[$];
  logic [7:0] rd_a [2];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  data_memory_arbiter #(.NUM_PORTS(2), .ADDR_W(8), .DATA_W(8), .INIT_MODE(1), .INIT_VALUE(8'h00)) dut_a (
    .clk(clk), .reset(reset), .init_req(init_req), .req(req_a), .we(we_a),
    .addr(addr_a), .wdata(wdata_a), .ack(ack_a), .rdata(rdata_a), .busy(busy_a)
  );

  data_memory_arbiter #(.NUM_PORTS(3), .ADDR_W(4), .DATA_W(8), .INIT_MODE(2), .INIT_VALUE(8'h5A)) dut_b (
    .clk(clk), .reset(reset), .init_req(init_req_b), .req(req_b), .we(we_b),
    .addr(addr_b), .wdata(wdata_b), .ack(ack_b), .rdata(rdata_b), .busy(busy_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      for (int p = 0; p < 2; p++) begin
        if (ack_a[p]) begin
          checks++;
          if (qa.size() == 0) begin
            errors++;
            $display("FAIL a_unexpected_ack: port %0d acked with nothing expected", p);
          end else begin
            e = qa.pop_front();
            if (e.port != p || rdata_a[p*8 +: 8] !== e.data) begin
              errors++;
              $display("FAIL a_response: got port %0d data 0x%0h expected port %0d data 0x%0h",
                       p, rdata_a[p*8 +: 8], e.port, e.data);
            end
          end
        end
      end
      for (int p = 0; p < 3; p++) begin
        if (ack_b[p]) begin
          checks++;
          if (qb.size() == 0) begin
            errors++;
            $display("FAIL b_unexpected_ack: port %0d acked with nothing expected", p);
          end else begin
            e = qb.pop_front();
            if (e.port != p || rdata_b[p*8 +: 8] !== e.data) begin
              errors++;
              $display("FAIL b_response: got port %0d data 0x%0h expected port %0d data 0x%0h",
                       p, rdata_b[p*8 +: 8], e.port, e.data);
            end
          end
        end
      end
    end
  end

  task automatic acc_a(input int p, input bit w, input logic [7:0] a, input logic [7:0] d,
                       input logic [7:0] expv);
    int n;
    @(posedge clk); #1;
    req_a[p] = 1'b1;
    we_a[p] = w;
    addr_a[p*8 +: 8] = a;
    wdata_a[p*8 +: 8] = d;
    if (w) begin
      qa.push_back(exp_t'{port: p, data: rd_a[p]});
    end else begin
      qa.push_back(exp_t'{port: p, data: expv});
      rd_a[p] = expv;
    end
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!ack_a[p] && n < 50);
    chk("a_latency", n, 1);
    req_a[p] = 1'b0;
    we_a[p] = 1'b0;
  endtask

  task automatic count_busy(input string name, input int expn);
    int n;
    n = 0;
    @(negedge clk);
    while (busy_a && n < 1000) begin
      n++;
      @(negedge clk);
    end
    chk(name, n, expn);
  endtask

  initial begin
    int n;
    rd_a[0] = 8'h00;
    rd_a[1] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ack", ack_a, 2'b00);
    chk("reset_rdata", rdata_a, 16'h0000);
    chk("reset_busy", busy_a, 1);
    reset = 1'b1;
    count_busy("a_fill_busy_cycles", 256);

    acc_a(0, 0, 8'h00, 8'h00, 8'h00);
    acc_a(0, 0, 8'h7F, 8'h00, 8'h7F);
    acc_a(0, 0, 8'hFF, 8'h00, 8'hFF);

    // Three-port instance: one read moves prio to 1, then 2 must win over 0.
    chk("b_busy_done", busy_b, 0);
    @(posedge clk); #1;
    req_b = 3'b001;
    addr_b[3:0] = 4'h3;
    qb.push_back(exp_t'{port: 0, data: 8'h5A});
    @(posedge clk); #1;
    chk("b_first_ack", ack_b, 3'b001);
    req_b = 3'b000;
    @(posedge clk); #1;
    req_b = 3'b101;
    we_b = 3'b100;
    addr_b[11:8] = 4'h4;
    wdata_b[23:16] = 8'hC3;
    addr_b[3:0] = 4'h4;
    qb.push_back(exp_t'{port: 2, data: 8'h00});
    qb.push_back(exp_t'{port: 0, data: 8'hC3});
    @(posedge clk); #1;
    chk("b_port2_first", ack_b, 3'b100);
    req_b[2] = 1'b0;
    @(posedge clk); #1;
    chk("b_port0_second", ack_b, 3'b001);
    req_b = 3'b000;
    we_b = 3'b000;

    acc_a(1, 0, 8'h11, 8'h00, 8'h11);
    acc_a(1, 1, 8'h10, 8'hA5, 8'h00);
    acc_a(0, 0, 8'h10, 8'h00, 8'hA5);
    acc_a(1, 0, 8'h12, 8'h00, 8'h12);

    @(posedge clk); #1;
    req_a = 2'b11;
    we_a = 2'b00;
    addr_a = {8'h30, 8'h20};
    for (int i = 0; i < 2; i++) begin
      qa.push_back(exp_t'{port: 0, data: 8'h20});
      qa.push_back(exp_t'{port: 1, data: 8'h30});
    end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("a_rr_ack", ack_a, (i % 2 == 0) ? 2'b01 : 2'b10);
    end
    req_a = 2'b00;
    rd_a[0] = 8'h20;
    rd_a[1] = 8'h30;

    acc_a(0, 1, 8'h05, 8'h33, 8'h00);
    @(posedge clk); #1;
    req_a[0] = 1'b1;
    we_a[0] = 1'b0;
    addr_a[7:0] = 8'h05;
    init_req = 1'b1;
    qa.push_back(exp_t'{port: 0, data: 8'h33});
    rd_a[0] = 8'h33;
    @(posedge clk); #1;
    init_req = 1'b0;
    req_a[0] = 1'b0;
    chk("a_initreq_ack", ack_a[0], 1);
    count_busy("a_refill_busy_cycles", 256);
    acc_a(0, 0, 8'h05, 8'h00, 8'h05);

    // Reset in the middle of a fill, then a read held across the restarted fill.
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("mid_reset_rdata", rdata_a, 16'h0000);
    chk("mid_reset_busy", busy_a, 1);
    rd_a[0] = 8'h00;
    rd_a[1] = 8'h00;
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (64) @(posedge clk);
    #1;
    chk("mid_fill_busy", busy_a, 1);
    reset = 1'b0;
    #1;
    chk("mid_fill_reset_ack", ack_a, 2'b00);
    req_a[0] = 1'b1;
    we_a[0] = 1'b0;
    addr_a[7:0] = 8'h20;
    qa.push_back(exp_t'{port: 0, data: 8'h20});
    rd_a[0] = 8'h20;
    @(posedge clk); #1;
    reset = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!ack_a[0] && n < 600);
    chk("a_refill_then_ack_cycles", n, 257);
    req_a = 2'b00;

    repeat (3) @(posedge clk);
    #1;
    chk("a_queue_drained", qa.size(), 0);
    chk("b_queue_drained", qb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
